// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one line-wide backing-memory port between the
// I-cache and D-cache refill controllers.
//
// Each cache issues one-cycle line requests. A request is latched in a
// per-port pending slot (or bypassed straight to grant when idle), one
// requester is granted at a time, the grant is forwarded to memory as a
// one-cycle mem_req pulse, and the single memory response is routed back
// to the owner as a one-cycle rvalid pulse.
//
// Ports:
//   clk, rstn                       clock, async active-low reset
//   i_req/i_addr                    I-cache line read request
//   i_rvalid/i_rdata                I-cache refill response
//   d_req/d_we/d_addr/d_wdata       D-cache line read or write-back request
//   d_rvalid/d_rdata                D-cache response (write ack has rdata=0)
//   mem_req/mem_we/mem_addr/mem_wdata   request to memory (addr line-aligned)
//   mem_rvalid/mem_rdata            memory response
//   busy                            high while a memory access is in flight
//   err_overrun                     sticky: request dropped, port already busy
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin on contention (grant the port not granted last)
//   undefined -> fixed priority, D wins over I on contention

module mem_refill_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_rvalid,
    output logic [LINE_BYTES*8-1:0] i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [LINE_BYTES*8-1:0] d_wdata,
    output logic                    d_rvalid,
    output logic [LINE_BYTES*8-1:0] d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic                    busy,
    output logic                    err_overrun
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    typedef enum logic { S_IDLE, S_WAIT } state_e;
    typedef enum logic { PORT_I, PORT_D } port_e;

    state_e                  state_q,     state_d;
    port_e                   owner_q,     owner_d;
    port_e                   last_q,      last_d;

    logic                    i_vld_q,     i_vld_d;
    logic [ADDR_WIDTH-1:0]   i_addr_q,    i_addr_d;
    logic                    d_vld_q,     d_vld_d;
    logic                    d_we_q,      d_we_d;
    logic [ADDR_WIDTH-1:0]   d_addr_q,    d_addr_d;
    logic [LINE_W-1:0]       d_wdata_q,   d_wdata_d;

    logic                    i_rvalid_q,  i_rvalid_d;
    logic [LINE_W-1:0]       i_rdata_q,   i_rdata_d;
    logic                    d_rvalid_q,  d_rvalid_d;
    logic [LINE_W-1:0]       d_rdata_q,   d_rdata_d;
    logic                    mem_req_q,   mem_req_d;
    logic                    mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic                    busy_q,      busy_d;
    logic                    err_q,       err_d;

    // Request acceptance, candidate selection and arbitration
    logic                    i_ovr, d_ovr, i_acc, d_acc, cand_i, cand_d, pick_d;
    logic [ADDR_WIDTH-1:0]   i_cand_addr, d_cand_addr;
    logic                    d_cand_we;
    logic [LINE_W-1:0]       d_cand_wdata;

    always_comb begin
        // A port is overrun if its slot is full or it owns the in-flight access
        i_ovr = i_req & (i_vld_q | ((state_q == S_WAIT) & (owner_q == PORT_I)));
        d_ovr = d_req & (d_vld_q | ((state_q == S_WAIT) & (owner_q == PORT_D)));
        i_acc = i_req & ~i_ovr;
        d_acc = d_req & ~d_ovr;

        // Candidates: pending slot, or this cycle's request bypassing the slot
        cand_i       = i_vld_q | i_acc;
        cand_d       = d_vld_q | d_acc;
        i_cand_addr  = i_vld_q ? i_addr_q  : i_addr;
        d_cand_addr  = d_vld_q ? d_addr_q  : d_addr;
        d_cand_we    = d_vld_q ? d_we_q    : d_we;
        d_cand_wdata = d_vld_q ? d_wdata_q : d_wdata;

`ifdef MEM_ARB_RR_EN
        pick_d = cand_d & (~cand_i | (last_q == PORT_I));
`else
        pick_d = cand_d;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        i_vld_d     = i_vld_q;
        i_addr_d    = i_addr_q;
        d_vld_d     = d_vld_q;
        d_we_d      = d_we_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        i_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q | i_ovr | d_ovr;

        if (i_acc) begin
            i_vld_d  = 1'b1;
            i_addr_d = i_addr;
        end
        if (d_acc) begin
            d_vld_d   = 1'b1;
            d_we_d    = d_we;
            d_addr_d  = d_addr;
            d_wdata_d = d_wdata;
        end

        case (state_q)
            S_IDLE: begin
                // mem_rvalid is deliberately ignored here
                if (cand_i | cand_d) begin
                    mem_req_d = 1'b1;
                    state_d   = S_WAIT;
                    if (pick_d) begin
                        owner_d     = PORT_D;
                        mem_we_d    = d_cand_we;
                        mem_addr_d  = d_cand_addr & ALIGN_MASK;
                        mem_wdata_d = d_cand_wdata;
                        d_vld_d     = 1'b0;
                    end else begin
                        owner_d     = PORT_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_cand_addr & ALIGN_MASK;
                        mem_wdata_d = '0;
                        i_vld_d     = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                    if (owner_q == PORT_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WAIT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            owner_q     <= PORT_I;
            last_q      <= PORT_I;
            i_vld_q     <= 1'b0;
            i_addr_q    <= '0;
            d_vld_q     <= 1'b0;
            d_we_q      <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            i_vld_q     <= i_vld_d;
            i_addr_q    <= i_addr_d;
            d_vld_q     <= d_vld_d;
            d_we_q      <= d_we_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign i_rvalid    = i_rvalid_q;
    assign i_rdata     = i_rdata_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_rdata     = d_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Testbench for mem_refill_arbiter: directed scenarios followed by random
// traffic, every cycle checked against a transaction-level reference model.
// Honors MEM_ARB_RR_EN the same way as the design.

module tb_mem_refill_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LB = 16;
    localparam int unsigned LW = LB * 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req, d_req, d_we, mem_rvalid;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic          i_rvalid, d_rvalid, mem_req, mem_we, busy, err_overrun;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_refill_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err_overrun(err_overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending requests per port, one in-flight access, and
    // the expected registered outputs.
    bit            s_i_v, s_d_v, s_d_we;
    logic [AW-1:0] s_i_a, s_d_a;
    logic [LW-1:0] s_d_w;
    bit            fl_busy, fl_d, fl_we, last_d, m_err;
    bit            e_mem_req, e_mem_we, e_i_rv, e_d_rv;
    logic [AW-1:0] e_mem_addr;
    logic [LW-1:0] e_mem_wdata, e_i_rd, e_d_rd;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(LB - 1);
    endfunction

    task automatic model_reset();
        s_i_v = 0; s_d_v = 0; s_d_we = 0; s_i_a = '0; s_d_a = '0; s_d_w = '0;
        fl_busy = 0; fl_d = 0; fl_we = 0; last_d = 0; m_err = 0;
        e_mem_req = 0; e_mem_we = 0; e_i_rv = 0; e_d_rv = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_i_rd = '0; e_d_rd = '0;
    endtask

    task automatic compare_all();
        check_val("mem_req",     LW'(mem_req),     LW'(e_mem_req));
        check_val("mem_we",      LW'(mem_we),      LW'(e_mem_we));
        check_val("mem_addr",    LW'(mem_addr),    LW'(e_mem_addr));
        check_val("mem_wdata",   mem_wdata,        e_mem_wdata);
        check_val("i_rvalid",    LW'(i_rvalid),    LW'(e_i_rv));
        check_val("i_rdata",     i_rdata,          e_i_rd);
        check_val("d_rvalid",    LW'(d_rvalid),    LW'(e_d_rv));
        check_val("d_rdata",     d_rdata,          e_d_rd);
        check_val("busy",        LW'(busy),        LW'(fl_busy));
        check_val("err_overrun", LW'(err_overrun), LW'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model, clock, compare everything
    task automatic step(input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input bit dwe, input logic [AW-1:0] da,
                        input logic [LW-1:0] dw, input bit mrv, input logic [LW-1:0] mrd);
        bit oi, od, pd;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        mem_rvalid = mrv; mem_rdata = mrd;

        oi = ir && (s_i_v || (fl_busy && !fl_d));
        od = dr && (s_d_v || (fl_busy && fl_d));
        if (oi || od) m_err = 1;
        e_mem_req = 0; e_i_rv = 0; e_d_rv = 0;

        if (fl_busy && mrv) begin
            fl_busy = 0;
            last_d  = fl_d;
            if (fl_d) begin e_d_rv = 1; e_d_rd = fl_we ? '0 : mrd; end
            else      begin e_i_rv = 1; e_i_rd = mrd; end
            if (ir && !oi) begin s_i_v = 1; s_i_a = ia; end
            if (dr && !od) begin s_d_v = 1; s_d_we = dwe; s_d_a = da; s_d_w = dw; end
        end else if (fl_busy) begin
            if (ir && !oi) begin s_i_v = 1; s_i_a = ia; end
            if (dr && !od) begin s_d_v = 1; s_d_we = dwe; s_d_a = da; s_d_w = dw; end
        end else begin
            // Idle: new requests join the pending set, then one is granted
            if (ir && !oi) begin s_i_v = 1; s_i_a = ia; end
            if (dr && !od) begin s_d_v = 1; s_d_we = dwe; s_d_a = da; s_d_w = dw; end
            if (s_i_v || s_d_v) begin
`ifdef MEM_ARB_RR_EN
                pd = (s_i_v && s_d_v) ? !last_d : s_d_v;
`else
                pd = s_d_v;
`endif
                e_mem_req = 1; fl_busy = 1; fl_d = pd;
                if (pd) begin
                    fl_we = s_d_we; e_mem_we = s_d_we; e_mem_addr = align(s_d_a);
                    e_mem_wdata = s_d_w; s_d_v = 0;
                end else begin
                    fl_we = 0; e_mem_we = 0; e_mem_addr = align(s_i_a);
                    e_mem_wdata = '0; s_i_v = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, 0, '0);
    endtask

    task automatic ack(input logic [LW-1:0] d);
        step(0, '0, 0, 0, '0, '0, 1, d);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        rstn = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; mem_rvalid = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [LW-1:0] first_a, second_a;

    initial begin
        rstn = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; mem_rvalid = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // Isolated I read
        step(1, 32'h0000_1234, 0, 0, '0, '0, 0, '0);
        check_val("t1_mem_req",  LW'(mem_req),  LW'(1'b1));
        check_val("t1_mem_we",   LW'(mem_we),   LW'(1'b0));
        check_val("t1_mem_addr", LW'(mem_addr), LW'(32'h0000_1230));
        idle(4);
        ack({16{8'hA5}});
        check_val("t1_i_rvalid", LW'(i_rvalid), LW'(1'b1));
        check_val("t1_i_rdata",  i_rdata,       {16{8'hA5}});
        check_val("t1_d_rvalid", LW'(d_rvalid), LW'(1'b0));
        idle(1);
        check_val("t1_pulse",    LW'(i_rvalid), LW'(1'b0));

        // D write-back
        step(0, '0, 1, 1, 32'h40, 128'h00112233445566778899AABBCCDDEEFF, 0, '0);
        check_val("t2_mem_we",    LW'(mem_we),   LW'(1'b1));
        check_val("t2_mem_addr",  LW'(mem_addr), LW'(32'h40));
        check_val("t2_mem_wdata", mem_wdata,     128'h00112233445566778899AABBCCDDEEFF);
        idle(2);
        ack(128'hDEAD_BEEF);
        check_val("t2_d_rvalid", LW'(d_rvalid), LW'(1'b1));
        check_val("t2_d_rdata",  d_rdata,       '0);
        idle(1);

        // Simultaneous requests; last grant was D here
`ifdef MEM_ARB_RR_EN
        first_a = LW'(32'h100); second_a = LW'(32'h200);
`else
        first_a = LW'(32'h200); second_a = LW'(32'h100);
`endif
        step(1, 32'h100, 1, 0, 32'h200, '0, 0, '0);
        check_val("t3_first", LW'(mem_addr), first_a);
        idle(1);
        ack(128'h1);
        check_val("t3_no_req_at_rsp", LW'(mem_req), LW'(1'b0));
        idle(1);
        check_val("t3_second_req",  LW'(mem_req),  LW'(1'b1));
        check_val("t3_second_addr", LW'(mem_addr), second_a);
        idle(1);
        ack(128'h2);
        idle(1);

        // Overrun: second I request while the first is in flight
        check_val("t4_err_before", LW'(err_overrun), LW'(1'b0));
        step(1, 32'h280, 0, 0, '0, '0, 0, '0);
        step(1, 32'h300, 0, 0, '0, '0, 0, '0);
        check_val("t4_err", LW'(err_overrun), LW'(1'b1));
        ack(128'h3);
        idle(2);
        check_val("t4_single_req", LW'(mem_req),  LW'(1'b0));
        check_val("t4_addr",       LW'(mem_addr), LW'(32'h280));

        // Reset while waiting, then a stale response
        step(1, 32'h500, 0, 0, '0, '0, 0, '0);
        idle(1);
        do_reset();
        ack(128'h55);
        check_val("t5_i_rvalid", LW'(i_rvalid), LW'(1'b0));
        check_val("t5_d_rvalid", LW'(d_rvalid), LW'(1'b0));
        check_val("t5_busy",     LW'(busy),     LW'(1'b0));
        check_val("t5_mem_addr", LW'(mem_addr), '0);

        // Spurious response while idle
        ack(128'h66);
        check_val("t6_i_rvalid", LW'(i_rvalid), LW'(1'b0));
        check_val("t6_d_rvalid", LW'(d_rvalid), LW'(1'b0));
        check_val("t6_busy",     LW'(busy),     LW'(1'b0));

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bit ir, dr, dwe, mrv;
            ir  = ($urandom_range(0, 5) == 0);
            dr  = ($urandom_range(0, 5) == 0);
            dwe = $urandom_range(0, 1) == 1;
            mrv = fl_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(ir, $urandom, dr, dwe, $urandom,
                     {$urandom, $urandom, $urandom, $urandom}, mrv,
                     {$urandom, $urandom, $urandom, $urandom});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
